// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: one digit per DIV-cycle slot, BLANK dead cycles before each enable.
// Latency: load reaches the display at the next frame start; a load in the boundary cycle bypasses pend_reg.
// Backpressure: none; the last load within a frame wins and earlier pending values are overwritten.
module seg_scan_mux #(
    parameter int NUM_DIGITS = 2,
    parameter int DIV        = 12000,
    parameter int BLANK      = 120
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lz_blank_en,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TW-1:0]           tick_cnt;
    logic [IW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    in_rst;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   lz_mask_nxt;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   sel;
    logic [3:0]              cur_nib;
    logic                    blank_cur;
    logic                    show;
    logic                    last_tick;
    logic                    last_digit;
    logic                    boundary;

    assign last_tick  = (tick_cnt == TW'(DIV - 1));
    assign last_digit = (digit_idx == IW'(NUM_DIGITS - 1));
    assign boundary   = !in_rst && last_tick && last_digit;

    // A digit is blanked when it and every higher nibble are zero; digit 0 never is.
    always_comb begin
        lz_mask_nxt = '0;
        zero_above  = 1'b1;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            zero_above     = zero_above && (disp_reg[4*d +: 4] == 4'h0);
            lz_mask_nxt[d] = lz_blank_en && zero_above;
        end
    end

    always_comb begin
        sel       = '0;
        cur_nib   = 4'h0;
        blank_cur = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx == IW'(d)) begin
                sel[d]    = 1'b1;
                cur_nib   = disp_reg[4*d +: 4];
                blank_cur = lz_mask[d];
            end
        end
        show = !in_rst && (tick_cnt >= TW'(BLANK)) && !blank_cur;
    end

    assign nibble_out  = cur_nib;
    assign digit_en_n  = show ? ~sel : '1;
    assign frame_start = !in_rst && (tick_cnt == '0) && (digit_idx == '0);

    // in_rst holds the scan at slot 0 for one cycle after release so frame_start is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
            disp_reg  <= '0;
            pend_reg  <= '0;
            pending   <= 1'b0;
            in_rst    <= 1'b1;
            lz_mask   <= '0;
        end else begin
            in_rst  <= 1'b0;
            lz_mask <= lz_mask_nxt;
            if (!in_rst) begin
                if (last_tick) begin
                    tick_cnt  <= '0;
                    digit_idx <= last_digit ? '0 : digit_idx + IW'(1);
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
            if (boundary) begin
                if (load) begin
                    disp_reg <= value_in;
                end else if (pending) begin
                    disp_reg <= pend_reg;
                end
                pending <= 1'b0;
            end else if (load) begin
                pend_reg <= value_in;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (2 digits, DIV=8, BLANK=2): reset/first-frame vector table,
// directed corner sequences and random traffic against a frame-position reference model.
module tb_seg_scan_mux;

    localparam int ND    = 2;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    value_in = 8'h00;
    logic          load = 1'b0;
    logic          lz_blank_en = 1'b0;
    logic [3:0]    nibble_out;
    logic [ND-1:0] digit_en_n;
    logic          frame_start;
    logic          pending;

    seg_scan_mux #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .load        (load),
        .lz_blank_en (lz_blank_en),
        .nibble_out  (nibble_out),
        .digit_en_n  (digit_en_n),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the frame plus displayed/pending values.
    int         m_t   = 0;
    bit         m_rst = 1'b1;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_pnd = 1'b0;
    bit         m_lzq = 1'b0;

    logic [ND-1:0] prev_en  = '1;
    logic [3:0]    prev_nib = 4'h0;

    typedef struct {
        bit         rst;
        bit         load;
        logic [7:0] val;
        logic [3:0] nib;
        logic [1:0] en;
        bit         fs;
        bit         pnd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic void model_edge(bit r, bit ld, logic [7:0] v, bit lz);
        bit bnd;
        if (r) begin
            m_rst = 1'b1; m_t = 0; m_disp = 8'h00; m_pend = 8'h00; m_pnd = 1'b0; m_lzq = 1'b0;
        end else begin
            bnd = !m_rst && (m_t == FRAME - 1);
            if (bnd) begin
                if (ld) m_disp = v;
                else if (m_pnd) m_disp = m_pend;
                m_pnd = 1'b0;
            end else if (ld) begin
                m_pend = v;
                m_pnd  = 1'b1;
            end
            if (!m_rst) m_t = (m_t + 1) % FRAME;
            m_rst = 1'b0;
            m_lzq = lz;
        end
    endfunction

    task automatic cyc(input bit r, input bit ld, input logic [7:0] v);
        int         slot;
        int         pos;
        logic [7:0] higher;
        logic [3:0] exp_nib;
        logic [1:0] one;
        logic [1:0] exp_en;
        bit         blanked;
        rst = r; load = ld; value_in = v;
        @(posedge clk);
        model_edge(r, ld, v, lz_blank_en);
        #1;
        slot    = m_t / DIV;
        pos     = m_t % DIV;
        higher  = m_disp >> (4 * slot);
        exp_nib = higher[3:0];
        blanked = m_lzq && (slot > 0) && (higher == 8'h00);
        one     = 2'b01;
        exp_en  = (!m_rst && pos >= BLANK && !blanked) ? ~(one << slot) : 2'b11;
        chk("model_nib", 32'(nibble_out), 32'(exp_nib));
        chk("model_en", 32'(digit_en_n), 32'(exp_en));
        chk("model_fs", 32'(frame_start), 32'(!m_rst && m_t == 0));
        chk("model_pend", 32'(pending), 32'(m_pnd));
        chk("one_enable", 32'($countones(~digit_en_n) <= 1), 32'(1));
        if (prev_en != '1 && digit_en_n != '1)
            chk("nib_stable", 32'(nibble_out), 32'(prev_nib));
        prev_en  = digit_en_n;
        prev_nib = nibble_out;
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_t != target && guard < 2 * FRAME) begin
            cyc(1'b0, 1'b0, 8'h00);
            guard++;
        end
        if (m_t != target) begin
            total++; bad++;
            $display("FAIL run_to: reached %0d required %0d", m_t, target);
        end
    endtask

    initial begin
        //          rst   load  val    nib   en     fs    pnd
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 4'h0, 2'b11, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 4'h0, 2'b11, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b11, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b11, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b10, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h3A, 4'h0, 2'b10, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b10, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b10, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b10, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b10, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b11, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b11, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 4'h0, 2'b01, 1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].rst, vecs[i].load, vecs[i].val);
            chk("vec_nib", 32'(nibble_out), 32'(vecs[i].nib));
            chk("vec_en", 32'(digit_en_n), 32'(vecs[i].en));
            chk("vec_fs", 32'(frame_start), 32'(vecs[i].fs));
            chk("vec_pend", 32'(pending), 32'(vecs[i].pnd));
        end

        // 3A becomes visible only after the frame boundary.
        run_to(15);
        chk("3a_pend_before", 32'(pending), 32'(1));
        cyc(1'b0, 1'b0, 8'h00);
        chk("3a_fs", 32'(frame_start), 32'(1));
        chk("3a_pend_after", 32'(pending), 32'(0));
        run_to(2);
        chk("3a_en0", 32'(digit_en_n), 32'(2'b10));
        chk("3a_nib0", 32'(nibble_out), 32'(4'hA));
        run_to(10);
        chk("3a_en1", 32'(digit_en_n), 32'(2'b01));
        chk("3a_nib1", 32'(nibble_out), 32'(4'h3));

        // Two loads in one frame: last one wins.
        run_to(3);
        cyc(1'b0, 1'b1, 8'h12);
        run_to(5);
        cyc(1'b0, 1'b1, 8'h45);
        run_to(2);
        chk("2ld_nib0", 32'(nibble_out), 32'(4'h5));
        run_to(10);
        chk("2ld_nib1", 32'(nibble_out), 32'(4'h4));

        // Load in the boundary cycle goes straight to the display.
        run_to(15);
        cyc(1'b0, 1'b1, 8'hC7);
        chk("bnd_pend", 32'(pending), 32'(0));
        chk("bnd_nib0", 32'(nibble_out), 32'(4'h7));
        chk("bnd_fs", 32'(frame_start), 32'(1));
        run_to(10);
        chk("bnd_nib1", 32'(nibble_out), 32'(4'hC));
        chk("bnd_en1", 32'(digit_en_n), 32'(2'b01));

        // Leading-zero blanking.
        lz_blank_en = 1'b1;
        cyc(1'b0, 1'b1, 8'h05);
        run_to(4);
        chk("lz05_en0", 32'(digit_en_n), 32'(2'b10));
        chk("lz05_nib0", 32'(nibble_out), 32'(4'h5));
        for (int i = 8; i < 16; i++) begin
            run_to(i);
            chk("lz05_slot1_off", 32'(digit_en_n), 32'(2'b11));
        end
        cyc(1'b0, 1'b1, 8'h00);
        run_to(4);
        chk("lz00_en0", 32'(digit_en_n), 32'(2'b10));
        chk("lz00_nib0", 32'(nibble_out), 32'(4'h0));
        run_to(10);
        chk("lz00_slot1_off", 32'(digit_en_n), 32'(2'b11));

        // Reset mid-slot with a value pending.
        cyc(1'b0, 1'b1, 8'h99);
        run_to(11);
        cyc(1'b0, 1'b1, 8'h77);
        chk("mid_pend_set", 32'(pending), 32'(1));
        cyc(1'b1, 1'b0, 8'h00);
        chk("mid_rst_en", 32'(digit_en_n), 32'(2'b11));
        chk("mid_rst_nib", 32'(nibble_out), 32'(4'h0));
        chk("mid_rst_pend", 32'(pending), 32'(0));
        chk("mid_rst_fs", 32'(frame_start), 32'(0));
        cyc(1'b0, 1'b0, 8'h00);
        chk("rel_fs", 32'(frame_start), 32'(1));
        chk("rel_nib", 32'(nibble_out), 32'(4'h0));
        run_to(4);
        chk("rel_en0", 32'(digit_en_n), 32'(2'b10));
        chk("rel_nib0", 32'(nibble_out), 32'(4'h0));

        // Random traffic against the model.
        lz_blank_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) lz_blank_en = ~lz_blank_en;
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scanner for a common-segment 7-segment display, directly upstream of the nibble-to-segment decoder.
- Holds a multi-digit hex value and cycles through the digits one at a time.
- For each digit it presents that digit's nibble to the decoder and drives the matching active-low digit enable.
- Includes a dead-time blank before each enable (anti-ghosting), frame-synchronous value update (no tearing) and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 2, number of digits scanned; legal range 1..8.
- DIV, 12000, clock cycles per digit slot (1 kHz slot rate at 12 MHz); must be >= 2.
- BLANK, 120, dead-time cycles at the start of each slot with all digits off; must satisfy 0 <= BLANK < DIV.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- value_in, input, 4*NUM_DIGITS, hex value to display; nibble i drives digit i; digit 0 is least significant.
- load, input, 1, capture strobe for value_in; sampled on the rising edge of clk.
- lz_blank_en, input, 1, 1 = leading-zero blanking enabled.
- nibble_out, output, 4, nibble of the current digit; feeds the decoder.
- digit_en_n, output, NUM_DIGITS, active-low digit enables; at most one bit is 0 at any time.
- frame_start, output, 1, high for exactly the first cycle of slot 0.
- pending, output, 1, a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset values: tick_cnt=0, digit_idx=0, disp_reg=0, pend_reg=0, pending=0.
- Outputs during reset: nibble_out=0, digit_en_n=all 1s, frame_start=0.
- Rst overrides everything, including a load in the same cycle.
- All outputs are functions of registered state only; there is no combinational path from any input to any output.
- tick_cnt counts 0..DIV-1, then wraps to 0.
- On each tick_cnt wrap, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
- Per-slot timing for current digit d:
  - Cycles 0..BLANK-1 of the slot: digit_en_n = all 1s.
  - Cycles BLANK..DIV-1: digit_en_n[d] = 0, all other bits 1, unless digit d is blanked.
  - nibble_out = disp_reg nibble d for the whole slot, so it is stable >= BLANK cycles before the enable asserts.
- Leading-zero blanking:
  - With lz_blank_en=1, digit d (d > 0) is blanked when nibble d and all higher nibbles of disp_reg are 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps digit_en_n all 1s for its entire slot. nibble_out is still driven.
  - lz_blank_en is evaluated combinationally against registered state and takes effect on the next cycle's outputs; it is the one exception to the no-path rule, acceptable as a quasi-static control.
- frame_start = 1 when tick_cnt==0 and digit_idx==0. This includes the first cycle after rst deasserts.
- Load handshake, general case: with load=1, value_in is captured into pend_reg and pending is set.
  - Repeated loads within a frame: the last one wins.
- Frame boundary is the last cycle of slot NUM_DIGITS-1, i.e. tick_cnt==DIV-1 and digit_idx==NUM_DIGITS-1.
  - If pending=1 at the boundary, disp_reg <= pend_reg and pending clears.
  - If pending=0, disp_reg is unchanged.
- Load in the boundary cycle: value_in goes directly into disp_reg and pending clears, so the new value shows from the next frame_start. Any older pend_reg value is discarded.
- NUM_DIGITS=1: every slot end is a frame boundary.
- BLANK=0: the enable asserts in cycle 0 of each slot.
- Reset mid-slot: the next cycle shows reset values. Any pending value is lost.

Test Plan:
- Use NUM_DIGITS=2, DIV=8, BLANK=2 unless stated.
- Reset, lz_blank_en=0 -> first cycle after reset: frame_start=1, nibble_out=0.
  - Cycles 0-1: digit_en_n=11; cycles 2-7: digit_en_n=10.
  - Cycles 8-9: 11; cycles 10-15: 01; frame_start=1 again at cycle 16.
- load value_in=8'h3A in slot 0 -> pending=1 until the boundary (cycle 15).
  - Next frame: slot 0 nibble_out=A, slot 1 nibble_out=3; pending=0.
- Two loads in one frame, 8'h12 then 8'h45 -> next frame shows 5 then 4; 8'h12 is never displayed.
- load 8'hC7 exactly at tick_cnt=7, digit_idx=1 -> pending stays 0; next frame shows 7 then C.
- lz_blank_en=1, value 8'h05 -> digit 0 enabled with nibble 5; digit 1 slot keeps digit_en_n=11 throughout.
  - Value 8'h00 -> digit 0 shows 0.
- Assert rst at tick_cnt=4 of slot 1 with pending=1 -> next cycle: digit_en_n=11, nibble_out=0, pending=0.
  - After release: frame_start=1 and the display shows 0.
- Throughout all runs -> never more than one digit_en_n bit low; nibble_out never changes while any enable is low.
